// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t      responder FSM states (IDLE, BUSY, RESP)
//   BYTE_LANES   lanes per 32-bit word
//   ADDR_LSB     byte-offset bits dropped to form the word index
//   RD_LAT_MIN/MAX  legal read-latency range; counter width covers RD_LAT_MAX-1
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTE_LANES = 4;
  localparam int ADDR_LSB   = 2;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 15;
  localparam int CNT_W      = 4;

  // Index width for an array of the given depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the load/store path
// (master) and the data-memory responder (slave).
//   req_valid/req_write/req_addr/req_wdata/req_be  request from master
//   req_ready                                      responder can accept
//   rsp_valid/rsp_rdata/rsp_err                    one-cycle response
//   stall                                          pipeline hold
interface dmem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  import dmem_pkg::*;

  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [BYTE_LANES-1:0] req_be;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word array.
//   clk      clock
//   en       access enable for this cycle
//   we       write (1) / read (0) when en
//   lane_we  per-byte-lane write enables, used when we
//   idx      word index
//   wdata    write word
//   rdata    registered read word; holds its value until the next read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] lane_we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
          if (lane_we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: services one load/store per transaction against an
// on-chip word array with configurable read latency and holds stall while
// a transaction is outstanding.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          dmem_responder_if slave port (request, response, stall)
// Build option: DMEM_BYTE_WRITE_EN enables per-lane store masking by req_be;
// without it every store writes the full word.
//
// state | meaning
// IDLE  | ready for a request; handshake = req_valid
// BUSY  | load in flight, latency counter counting down to 1
// RESP  | one-cycle response pulse, then back to IDLE
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int RD_LAT          = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = idx_width(MEM_DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(MEM_DEPTH_WORDS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;

  logic [ADDR_WIDTH-3:0]  widx;
  logic                   req_err;
  logic                   arr_en, arr_we;
  logic [BYTE_LANES-1:0]  lane_we;
  logic [31:0]            arr_rdata;

  assign widx    = bus.req_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign req_err = (bus.req_addr[ADDR_LSB-1:0] != '0) || (widx >= DEPTH_LIM);

`ifdef DMEM_BYTE_WRITE_EN
  assign lane_we = bus.req_be;
`else
  logic unused_be;
  assign unused_be = ^bus.req_be;
  assign lane_we   = '1;
`endif

  // Stores land on the handshake edge; loads read on it and the registered
  // array output is held until RESP.
  dmem_array #(
    .DEPTH (MEM_DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .en      (arr_en),
    .we      (arr_we),
    .lane_we (lane_we),
    .idx     (widx[IDX_W-1:0]),
    .wdata   (bus.req_wdata),
    .rdata   (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    arr_en  = 1'b0;
    arr_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d   = bus.req_write;
          err_d  = req_err;
          arr_en = !req_err;
          arr_we = bus.req_write && !req_err;
          if (req_err || bus.req_write) begin
            state_d = RESP;
          end else begin
            // The array register supplies one cycle; the counter covers the rest.
            cnt_d   = CNT_W'(RD_LAT - 1);
            state_d = (RD_LAT == 1) ? RESP : BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.stall     = (state_q != IDLE) || bus.req_valid;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_rdata = ((state_q == RESP) && !wr_q && !err_q) ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        sel;          // 0: RD_LAT=2 instance, 1: RD_LAT=1 instance
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  int n_cmp;
  int n_bad;

  dmem_responder_if #(.ADDR_WIDTH(32)) b2 ();
  dmem_responder_if #(.ADDR_WIDTH(32)) b1 ();

  assign b2.req_valid = req_valid & ~sel;
  assign b1.req_valid = req_valid & sel;
  assign b2.req_write = req_write;
  assign b1.req_write = req_write;
  assign b2.req_addr  = req_addr;
  assign b1.req_addr  = req_addr;
  assign b2.req_wdata = req_wdata;
  assign b1.req_wdata = req_wdata;
  assign b2.req_be    = req_be;
  assign b1.req_be    = req_be;

  logic        o_ready, o_rspv, o_err, o_stall;
  logic [31:0] o_rdata;
  assign o_ready = sel ? b1.req_ready : b2.req_ready;
  assign o_rspv  = sel ? b1.rsp_valid : b2.rsp_valid;
  assign o_err   = sel ? b1.rsp_err   : b2.rsp_err;
  assign o_stall = sel ? b1.stall     : b2.stall;
  assign o_rdata = sel ? b1.rsp_rdata : b2.rsp_rdata;

  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH), .RD_LAT(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH), .RD_LAT(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural store merge.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
`ifdef DMEM_BYTE_WRITE_EN
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
`else
    r = nw;
`endif
    return r;
  endfunction

  function automatic logic addr_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  // One transaction: drive at a negedge in IDLE, return data, error and the
  // number of cycles from handshake to rsp_valid (0 on timeout).
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
    #1;
    chk("ready_idle", 32'(o_ready), 32'd1);
    chk("stall_hs", 32'(o_stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (o_rspv) begin
        lat = c; rd = o_rdata; er = o_err;
        chk("stall_resp", 32'(o_stall), 32'd1);
        break;
      end
      chk("ready_busy", 32'(o_ready), 32'd0);
      @(negedge clk);
    end
    if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] win [16];   // model of words 0x100..0x13C in the RD_LAT=2 instance

  initial begin : main
    logic [31:0] rd, merged;
    logic        er;
    int          lat;
    n_cmp = 0; n_bad = 0;
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(b2.req_ready), 32'd1);
    chk("rst_rspv", 32'(b2.rsp_valid), 32'd0);
    chk("rst_rdata", b2.rsp_rdata, 32'd0);
    chk("rst_err", 32'(b2.rsp_err), 32'd0);
    chk("rst_stall", 32'(b2.stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DMEM_BYTE_WRITE_EN
    merged = 32'h11BB33DD;
`else
    merged = 32'hAABBCCDD;
`endif
    vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2});
    vecs.push_back('{1'b0, 32'h13,   32'h0,        4'h0, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2});
    vecs.push_back('{1'b1, 32'h0,    32'h12345678, 4'hF, 32'h0,        1'b0, 1});
    vecs.push_back('{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0, 2});
    vecs.push_back('{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0, 1});
    vecs.push_back('{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 1});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        4'h0, merged,       1'b0, 2});
    vecs.push_back('{1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1});
    vecs.push_back('{1'b0, 32'hFFC,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 2});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b1, 32'h1002, 32'h55555555, 4'hF, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b1, 32'h11,   32'h0BADF00D, 4'hF, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2});

    foreach (vecs[i]) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Reset in the middle of a load: response is dropped.
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_busy", 32'(b2.req_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(b2.req_ready), 32'd1);
    chk("midrst_rspv", 32'(b2.rsp_valid), 32'd0);
    chk("midrst_stall", 32'(b2.stall), 32'd0);
    rst_n = 1'b1;
    begin
      int pulses = 0;
      repeat (6) begin
        @(negedge clk);
        if (b2.rsp_valid) pulses++;
      end
      chk("midrst_no_pulse", 32'(pulses), 32'd0);
    end
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("postrst_array_kept", rd, 32'hDEADBEEF);

    // Randomized traffic against a window model.
    for (int k = 0; k < 16; k++) begin
      win[k] = $urandom;
      do_txn(1'b1, 32'h100 + 32'(4*k), win[k], 4'hF, rd, er, lat);
    end
    for (int t = 0; t < 250; t++) begin
      int          kind, k;
      logic        w;
      logic [31:0] a, wd, e_rd;
      logic [3:0]  be;
      logic        e_er;
      int          e_lat;
      kind = $urandom_range(0, 9);
      k    = $urandom_range(0, 15);
      w    = $urandom_range(0, 1) == 1;
      wd   = $urandom;
      be   = 4'($urandom);
      case (kind)
        0, 1, 2, 3: begin a = 32'h100 + 32'(4*k); w = 1'b0; end
        4, 5, 6:    begin a = 32'h100 + 32'(4*k); w = 1'b1; end
        7:          a = 32'h100 + 32'(4*k) + 32'($urandom_range(1, 3));
        8:          a = 32'h1000 + 32'(4 * $urandom_range(0, 1000));
        default:    a = $urandom | 32'h1000;
      endcase
      e_er = addr_err(a);
      e_rd = 32'h0;
      if (e_er || w) e_lat = 1;
      else begin
        e_lat = 2;
        e_rd  = win[(a - 32'h100) / 4];
      end
      do_txn(w, a, wd, be, rd, er, lat);
      if (!e_er && w) win[(a - 32'h100) / 4] = merge(win[(a - 32'h100) / 4], wd, be);
      chk($sformatf("rnd%0d_rdata a=%h", t, a), rd, e_rd);
      chk($sformatf("rnd%0d_err a=%h", t, a), 32'(er), 32'(e_er));
      chk($sformatf("rnd%0d_lat a=%h", t, a), 32'(lat), 32'(e_lat));
    end

    // Back-to-back loads, RD_LAT=1, req_valid held.
    sel = 1'b1;
    do_txn(1'b1, 32'h40, 32'hA0A0A0A0, 4'hF, rd, er, lat);
    do_txn(1'b1, 32'h44, 32'hB1B1B1B1, 4'hF, rd, er, lat);
    do_txn(1'b1, 32'h48, 32'hC2C2C2C2, 4'hF, rd, er, lat);
    begin
      logic [31:0] exp_d [3];
      logic [31:0] got_d [3];
      int hs_c [3];
      int n_hs, n_rsp, stall_low;
      exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'hB1B1B1B1; exp_d[2] = 32'hC2C2C2C2;
      n_hs = 0; n_rsp = 0; stall_low = 0;
      @(negedge clk);
      req_write = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (o_rspv && n_rsp < 3) begin
          got_d[n_rsp] = o_rdata;
          n_rsp++;
        end
        if (!o_stall) stall_low++;
        if (o_ready && req_valid) begin
          hs_c[n_hs] = c;
          n_hs++;
        end
        if (n_hs == 3 && n_rsp == 3) break;
        @(negedge clk);
        if (n_hs == 3) req_valid = 1'b0;
        else req_addr = 32'h40 + 32'(4*n_hs);
      end
      req_valid = 1'b0;
      chk("b2b_handshakes", 32'(n_hs), 32'd3);
      chk("b2b_responses", 32'(n_rsp), 32'd3);
      chk("b2b_stall_high", 32'(stall_low), 32'd0);
      if (n_hs == 3) begin
        chk("b2b_gap01", 32'(hs_c[1] - hs_c[0]), 32'd2);
        chk("b2b_gap12", 32'(hs_c[2] - hs_c[1]), 32'd2);
      end
      for (int i = 0; i < n_rsp; i++) chk($sformatf("b2b_data%0d", i), got_d[i], exp_d[i]);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
